// File: rtl/maxnet_pkg.sv
// Shared types and constants for the four-neuron MAXNET iterator.
// Optional macro MAXNET_TIMEOUT_EN enables the iteration cap.
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  localparam int DW  = 8;
  localparam int SW  = 10;
  localparam int EPS = 3;
  localparam int CW  = 6;
  localparam int CAP = 63;

  // Caller guarantees a one-hot input; lowest set bit wins otherwise.
  function automatic logic [1:0] hot_idx(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/maxnet_neuron.sv
// One MAXNET neuron: activation register with saturating
// lateral-inhibition update reg <= max(0, reg - ((S - reg) >> 3)).
module maxnet_neuron
  import maxnet_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          upd,
  input  logic [DW-1:0] init,
  input  logic [SW-1:0] sum,
  output logic [DW-1:0] q
);

  logic [DW-1:0] inh;
  logic [DW-1:0] nxt;

  // Three other neurons at most 765 total, so inh fits in 8 bits.
  assign inh = DW'((sum - SW'(q)) >> EPS);
  assign nxt = (inh >= q) ? '0 : q - inh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= init;
    end else if (upd) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/maxnet_iter.sv
// MAXNET winner-take-all iterator over four 8-bit neurons.
// Define MAXNET_TIMEOUT_EN to add the 63-iteration cap and timeout.
module maxnet_iter
  import maxnet_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  input  logic          finished,
  output logic [3:0]    active,
  output logic          busy,
  output logic          done,
  output logic [1:0]    winner,
  output logic [DW-1:0] value,
  output logic          zero,
  output logic          timeout
);

  state_t        state, nxt;
  logic          load, upd;
  logic          ex_win, ex_zero, ex_to;
  logic          cap_hit;
  logic [DW-1:0] xs [4];
  logic [DW-1:0] r  [4];
  logic [SW-1:0] sum;
  logic [1:0]    idx;

  assign xs[0] = x0;
  assign xs[1] = x1;
  assign xs[2] = x2;
  assign xs[3] = x3;

  assign sum = SW'(r[0]) + SW'(r[1]) + SW'(r[2]) + SW'(r[3]);

  for (genvar i = 0; i < 4; i++) begin : g_neuron
    maxnet_neuron u_neuron (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .upd  (upd),
      .init (xs[i]),
      .sum  (sum),
      .q    (r[i])
    );
    assign active[i] = (r[i] != '0);
  end

`ifdef MAXNET_TIMEOUT_EN
  logic [CW-1:0] cnt;
  logic          to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (upd) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cap_hit = (cnt == CW'(CAP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= 1'b0;
    end else if (load) begin
      to_q <= 1'b0;
    end else if (ex_win || ex_zero || ex_to) begin
      to_q <= ex_to;
    end
  end

  assign timeout = to_q;
`else
  // Without the cap, tied nonzero activations iterate forever.
  assign cap_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = state;
    load    = 1'b0;
    upd     = 1'b0;
    ex_win  = 1'b0;
    ex_zero = 1'b0;
    ex_to   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = CHECK;
        end
      end
      CHECK: begin
        if (finished) begin
          ex_win = 1'b1;
          nxt    = DONE;
        end else if (active == 4'b0000) begin
          ex_zero = 1'b1;
          nxt     = DONE;
        end else if (cap_hit) begin
          ex_to = 1'b1;
          nxt   = DONE;
        end else begin
          upd = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state == CHECK) || (state == DONE);
  assign done = (state == DONE);
  assign idx  = hot_idx(active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner <= '0;
      value  <= '0;
      zero   <= 1'b0;
    end else if (load) begin
      winner <= '0;
      value  <= '0;
      zero   <= 1'b0;
    end else if (ex_win || ex_zero || ex_to) begin
      winner <= ex_win ? idx : 2'd0;
      value  <= ex_win ? r[idx] : '0;
      zero   <= ex_zero;
    end
  end

endmodule

// File: tb/tb_maxnet_iter.sv
// Directed bench for maxnet_iter with a one-hot check stage
// closing the finished loop.
module tb_maxnet_iter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic       finished;
  logic [3:0] active;
  logic       busy, done, zero, timeout;
  logic [1:0] winner;
  logic [7:0] value;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Downstream check stage.
  assign finished = $onehot(active);

  maxnet_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .finished(finished),
    .active  (active),
    .busy    (busy),
    .done    (done),
    .winner  (winner),
    .value   (value),
    .zero    (zero),
    .timeout (timeout)
  );

  task automatic launch(input logic [7:0] a, b, c, d,
                        input int budget, output int lat);
    @(negedge clk);
    x0 = a; x1 = b; x2 = c; x3 = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < budget) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic finish_done();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({busy, done, active, winner, value, zero, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0",
               {busy, done, active, winner, value, zero, timeout});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_single_win();
    int lat;
    launch(8'd0, 8'd0, 8'd0, 8'd90, 10, lat);
    n_run++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL win_latency: got %0d want 2", lat);
    end
    n_run++;
    if ({winner, value, zero, timeout} !== {2'd3, 8'd90, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL win_result: got w=%0d v=%0d z=%b t=%b want 3 90 0 0",
               winner, value, zero, timeout);
    end
    finish_done();
    n_run++;
    if (busy !== 1'b0 || done !== 1'b0 || winner !== 2'd3 || value !== 8'd90) begin
      n_fail++;
      $display("FAIL win_hold: busy=%b done=%b w=%0d v=%0d want 0 0 3 90",
               busy, done, winner, value);
    end
  endtask

  task automatic test_one_iter();
    int lat;
    launch(8'd100, 8'd10, 8'd0, 8'd0, 10, lat);
    n_run++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL iter_latency: got %0d want 3", lat);
    end
    n_run++;
    if ({winner, value, zero, timeout} !== {2'd0, 8'd99, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL iter_result: got w=%0d v=%0d z=%b t=%b want 0 99 0 0",
               winner, value, zero, timeout);
    end
    n_run++;
    if (active !== 4'b0001) begin
      n_fail++;
      $display("FAIL iter_active: got %b want 0001", active);
    end
    finish_done();
  endtask

  task automatic test_all_zero();
    int lat;
    launch(8'd0, 8'd0, 8'd0, 8'd0, 10, lat);
    n_run++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d want 2", lat);
    end
    n_run++;
    if ({winner, value, zero, timeout} !== {2'd0, 8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_result: got w=%0d v=%0d z=%b t=%b want 0 0 1 0",
               winner, value, zero, timeout);
    end
    finish_done();
  endtask

  task automatic test_tie();
    int lat;
`ifdef MAXNET_TIMEOUT_EN
    launch(8'd64, 8'd64, 8'd64, 8'd64, 100, lat);
    n_run++;
    if (lat !== 65) begin
      n_fail++;
      $display("FAIL tie_latency: got %0d want 65", lat);
    end
    n_run++;
    if ({winner, value, zero, timeout} !== {2'd0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL tie_result: got w=%0d v=%0d z=%b t=%b want 0 0 0 1",
               winner, value, zero, timeout);
    end
`else
    launch(8'd64, 8'd64, 8'd64, 8'd64, 100, lat);
    n_run++;
    if (lat !== -1 || busy !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_forever: lat=%0d busy=%b t=%b want -1 1 0",
               lat, busy, timeout);
    end
`endif
    n_run++;
    if (active !== 4'b1111) begin
      n_fail++;
      $display("FAIL tie_active: got %b want 1111", active);
    end
    n_run++;
    if (dut.g_neuron[0].u_neuron.q !== 8'd2 ||
        dut.g_neuron[1].u_neuron.q !== 8'd2 ||
        dut.g_neuron[2].u_neuron.q !== 8'd2 ||
        dut.g_neuron[3].u_neuron.q !== 8'd2) begin
      n_fail++;
      $display("FAIL tie_regs: got %0d %0d %0d %0d want 2 2 2 2",
               dut.g_neuron[0].u_neuron.q, dut.g_neuron[1].u_neuron.q,
               dut.g_neuron[2].u_neuron.q, dut.g_neuron[3].u_neuron.q);
    end
`ifdef MAXNET_TIMEOUT_EN
    finish_done();
`else
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  task automatic test_reset_mid();
    int saw_done;
    saw_done = 0;
    @(negedge clk);
    x0 = 8'd64; x1 = 8'd64; x2 = 8'd64; x3 = 8'd64;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_run++;
    if ({busy, done, active, winner, value, zero, timeout} !== '0) begin
      n_fail++;
      $display("FAIL abort_outs: got %b want 0",
               {busy, done, active, winner, value, zero, timeout});
    end
    repeat (3) begin
      @(posedge clk);
      #1 if (done) saw_done = 1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 if (done || busy) saw_done = 1;
    end
    n_run++;
    if (saw_done !== 0) begin
      n_fail++;
      $display("FAIL abort_nodone: got %0d want 0", saw_done);
    end
  endtask

  task automatic test_busy_start();
    int extra;
    extra = 0;
    @(negedge clk);
    x0 = 8'd0; x1 = 8'd0; x2 = 8'd0; x3 = 8'd90;
    start = 1'b1;
    @(posedge clk);
    #1 x0 = 8'd0; x1 = 8'd50; x2 = 8'd0; x3 = 8'd0;
    @(posedge clk);
    #1;
    n_run++;
    if (done !== 1'b1 || winner !== 2'd3 || value !== 8'd90) begin
      n_fail++;
      $display("FAIL busy_done: done=%b w=%0d v=%0d want 1 3 90",
               done, winner, value);
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (busy || done) extra = 1;
    end
    n_run++;
    if (extra !== 0 || winner !== 2'd3 || value !== 8'd90 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: extra=%0d w=%0d v=%0d z=%b want 0 3 90 0",
               extra, winner, value, zero);
    end
  endtask

  initial begin
    test_reset();
    test_single_win();
    test_one_iter();
    test_all_zero();
    test_tie();
    test_reset_mid();
    test_busy_start();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
